bar_graph_multi_renderer: RTL and testbench

Parametrised successor to the single-bar plotter in the Visuals path. It draws NUM_BARS vertical bars side by side, one pixel per cycle, into the VGA plot interface. Each bar grows upward from a common baseline. Every pass repaints the full MAX_H column, so a shrinking bar is erased without a separate clear. A start/busy/done handshake lets the top-level FSM sequence redraws.

---
 rtl/bar_graph_multi_renderer.sv | 178 +++++++++++++++++
 tb/tb_bar_graph_multi_renderer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_graph_multi_renderer.sv
// Draws NUM_BARS vertical bars, one pixel per cycle, repainting each full MAX_H column
// so a shrinking bar is erased in the same pass. A start/busy/done handshake sequences redraws.
module bar_graph_multi_renderer #(
    parameter int NUM_BARS = 4,
    parameter int BAR_W    = 8,
    parameter int BAR_GAP  = 4,
    parameter int MAX_H    = 100,
    parameter int H_W      = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    clear_only,
    input  logic [8:0]              base_x,
    input  logic [7:0]              base_y,
    input  logic [NUM_BARS*H_W-1:0] heights,
    input  logic [2:0]              bar_colour,
    input  logic [2:0]              bg_colour,
    output logic [8:0]              x_coord,
    output logic [7:0]              y_coord,
    output logic [2:0]              colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    done
);
    localparam int IW     = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int CW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int STRIDE = BAR_W + BAR_GAP;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t                     state_q, state_d;
    logic [8:0]                 bx_q, bx_d;
    logic [7:0]                 by_q, by_d;
    logic [2:0]                 barc_q, barc_d;
    logic [2:0]                 bgc_q, bgc_d;
    logic [NUM_BARS-1:0][7:0]   h_q, h_d, h_in;
    logic [IW-1:0]              i_q, i_d, ni;
    logic [7:0]                 r_q, r_d, nr;
    logic [CW-1:0]              c_q, c_d, nc;
    logic                       last;
    logic [8:0]                 x_q, x_d;
    logic [7:0]                 y_q, y_d;
    logic [2:0]                 col_q, col_d;
    logic                       plot_q, plot_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    // Heights as they will be latched: erase forces zero, otherwise clamp to the column height.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BARS; gi++) begin : g_clamp
            assign h_in[gi] = clear_only ? 8'd0 :
                              (32'(heights[gi*H_W +: H_W]) > 32'(MAX_H)) ? 8'(MAX_H) :
                              8'(heights[gi*H_W +: H_W]);
        end
    endgenerate

    // Scan position of the pixel following the one currently on the outputs.
    always_comb begin
        last = (i_q == IW'(NUM_BARS - 1)) && (r_q == 8'(MAX_H - 1)) && (c_q == CW'(BAR_W - 1));
        ni   = i_q;
        nr   = r_q;
        nc   = c_q + 1'b1;
        if (c_q == CW'(BAR_W - 1)) begin
            nc = '0;
            if (r_q == 8'(MAX_H - 1)) begin
                nr = '0;
                ni = i_q + 1'b1;
            end else begin
                nr = r_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        barc_d  = barc_q;
        bgc_d   = bgc_q;
        h_d     = h_q;
        i_d     = i_q;
        r_d     = r_q;
        c_d     = c_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        plot_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRAW;
                    bx_d    = base_x;
                    by_d    = base_y;
                    barc_d  = bar_colour;
                    bgc_d   = bg_colour;
                    h_d     = h_in;
                    i_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    // First pixel comes straight from the inputs so it appears the cycle after start.
                    x_d     = base_x;
                    y_d     = base_y;
                    col_d   = (h_in[0] != 8'd0) ? bar_colour : bg_colour;
                    plot_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            DRAW: begin
                if (last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    i_d    = ni;
                    r_d    = nr;
                    c_d    = nc;
                    x_d    = 9'(32'(bx_q) + 32'(ni) * 32'(STRIDE) + 32'(nc));
                    y_d    = by_q - nr;
                    col_d  = (nr < h_q[ni]) ? barc_q : bgc_q;
                    plot_d = 1'b1;
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bx_q    <= '0;
            by_q    <= '0;
            barc_q  <= '0;
            bgc_q   <= '0;
            h_q     <= '0;
            i_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            barc_q  <= barc_d;
            bgc_q   <= bgc_d;
            h_q     <= h_d;
            i_q     <= i_d;
            r_q     <= r_d;
            c_q     <= c_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x_coord = x_q;
    assign y_coord = y_q;
    assign colour  = col_q;
    assign plot    = plot_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_bar_graph_multi_renderer.sv
// Bench for bar_graph_multi_renderer: a queue-based pixel model checked every cycle,
// directed scenarios with literal expectations, and randomized passes with input noise.
module tb_bar_graph_multi_renderer;
    localparam int NB = 2, BW = 2, BG = 1, MH = 4, HW = 3;
    localparam int N  = NB * BW * MH;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, clear_only = 1'b0;
    logic [8:0]    base_x = '0;
    logic [7:0]    base_y = '0;
    logic [NB*HW-1:0] heights = '0;
    logic [2:0]    bar_colour = 3'b010, bg_colour = 3'b000;
    logic [8:0]    x_coord;
    logic [7:0]    y_coord;
    logic [2:0]    colour;
    logic          plot, busy, done;

    bar_graph_multi_renderer #(.NUM_BARS(NB), .BAR_W(BW), .BAR_GAP(BG), .MAX_H(MH), .H_W(HW)) dut (
        .clk(clk), .reset(reset), .start(start), .clear_only(clear_only),
        .base_x(base_x), .base_y(base_y), .heights(heights),
        .bar_colour(bar_colour), .bg_colour(bg_colour),
        .x_coord(x_coord), .y_coord(y_coord), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } px_t;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", nm, cyc, act, expv);
        end
    endtask

    // Reference model: on an accepted start, the whole pass is generated as a list of pixels
    // straight from the drawing rules; one list entry appears per cycle, then a done cycle.
    px_t  exp_q[$];
    px_t  e_px = '0;
    logic e_plot = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    bit   e_pix_chk = 1'b1;
    int   m_phase = 0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            m_phase = 0; e_plot = 0; e_busy = 0; e_done = 0; e_px = '0; e_pix_chk = 1;
        end else if (m_phase == 0) begin
            e_done = 0;
            if (start) begin
                exp_q.delete();
                for (int i = 0; i < NB; i++) begin
                    int h;
                    h = int'(heights[i*HW +: HW]);
                    if (h > MH) h = MH;
                    if (clear_only) h = 0;
                    for (int r = 0; r < MH; r++)
                        for (int c = 0; c < BW; c++) begin
                            px_t p;
                            p.x = 9'((int'(base_x) + i * (BW + BG) + c) % 512);
                            p.y = 8'((int'(base_y) - r + 256) % 256);
                            p.c = (r < h) ? bar_colour : bg_colour;
                            exp_q.push_back(p);
                        end
                end
                e_px = exp_q.pop_front();
                e_plot = 1; e_busy = 1; e_pix_chk = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (exp_q.size() == 0) begin
                e_plot = 0; e_busy = 0; e_done = 1; e_pix_chk = 0; m_phase = 2;
            end else begin
                e_px = exp_q.pop_front();
            end
        end else begin
            e_done = 0; m_phase = 0;
        end
    end

    // Per-cycle comparison plus a log of what the DUT actually plotted.
    px_t obs[$];
    int  obs_cyc[$];
    int  done_cnt = 0, done_cyc = -1;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("plot", 32'(plot), 32'(e_plot));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            if (e_pix_chk) begin
                chk("x", 32'(x_coord), 32'(e_px.x));
                chk("y", 32'(y_coord), 32'(e_px.y));
                chk("colour", 32'(colour), 32'(e_px.c));
            end
            if (plot === 1'b1) begin
                obs.push_back({x_coord, y_coord, colour});
                obs_cyc.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Drives one start; k is the number of the clock edge that samples it.
    task automatic launch(input int h0, input int h1, input int bx, input int by, input bit clr,
                          output int k);
        obs.delete(); obs_cyc.delete(); done_cnt = 0; done_cyc = -1;
        @(negedge clk);
        heights = {3'(h1), 3'(h0)}; base_x = 9'(bx); base_y = 8'(by); clear_only = clr; start = 1;
        @(negedge clk);
        k = cyc;
        start = 0;
    endtask

    task automatic wait_done(input bit noisy);
        int t = 0;
        while (done_cnt == 0 && t < 40) begin
            @(negedge clk);
            t++;
            if (noisy && done_cnt == 0) begin
                heights = 6'($urandom); base_x = 9'($urandom); base_y = 8'($urandom);
                clear_only = 1'($urandom); start = 1'($urandom);
            end
        end
        start = 0;
        chk("done_seen", 32'(done_cnt > 0), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic report(input string nm, input int k);
        $display("pass %s: start edge %0d, pixels %0d, done pulses %0d", nm, k, obs.size(), done_cnt);
    endtask

    initial begin
        int k, cnt;
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);

        // Basic pass
        launch(3, 1, 10, 50, 0, k);
        wait_done(0);
        report("basic", k);
        chk("basic_count", obs.size(), 16);
        chk("basic_first_cycle", obs_cyc[0] + 1, k + 1);
        chk("basic_last_cycle", obs_cyc[obs.size()-1] + 1, k + 16);
        chk("basic_done_cycle", done_cyc + 1, k + 17);
        chk("basic_p0", 32'(obs[0]), 32'({9'd10, 8'd50, 3'b010}));
        chk("basic_p1", 32'(obs[1]), 32'({9'd11, 8'd50, 3'b010}));
        chk("basic_p2", 32'(obs[2]), 32'({9'd10, 8'd49, 3'b010}));
        chk("basic_p3", 32'(obs[3]), 32'({9'd11, 8'd49, 3'b010}));
        chk("basic_y47_a", 32'(obs[6]), 32'({9'd10, 8'd47, 3'b000}));
        chk("basic_y47_b", 32'(obs[7]), 32'({9'd11, 8'd47, 3'b000}));
        chk("bar1_p0", 32'(obs[8]), 32'({9'd13, 8'd50, 3'b010}));
        chk("bar1_p1", 32'(obs[9]), 32'({9'd14, 8'd50, 3'b010}));
        chk("bar1_p2", 32'(obs[10]), 32'({9'd13, 8'd49, 3'b000}));
        cnt = 0;
        foreach (obs[j]) if (obs[j].x == 9'd12) cnt++;
        chk("gap_x12_plots", cnt, 0);

        // Clamp
        launch(7, 0, 10, 50, 0, k);
        wait_done(0);
        report("clamp", k);
        cnt = 0;
        for (int j = 0; j < 8; j++) if (obs[j].c == 3'b010) cnt++;
        chk("clamp_bar0_filled", cnt, 8);

        // Erase
        launch(4, 4, 10, 50, 1, k);
        wait_done(0);
        report("erase", k);
        cnt = 0;
        foreach (obs[j]) if (obs[j].c == 3'b000) cnt++;
        chk("erase_bg_pixels", cnt, 16);

        // Start ignored while drawing, heights changed mid-pass
        launch(3, 1, 10, 50, 0, k);
        while (cyc < k + 2) @(negedge clk);
        heights = '0;
        while (cyc < k + 4) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done(0);
        repeat (N) @(negedge clk);
        report("ignore", k);
        chk("ignore_count", obs.size(), 16);
        chk("ignore_done_pulses", done_cnt, 1);
        chk("ignore_row1_bar0", 32'(obs[2].c), 32'(3'b010));
        chk("ignore_bar1_base", 32'(obs[8].c), 32'(3'b010));

        // Reset mid-pass
        launch(3, 1, 10, 50, 0, k);
        while (cyc < k + 5) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        repeat (25) @(negedge clk);
        report("reset", k);
        chk("reset_pixels", obs.size(), 6);
        chk("reset_done_pulses", done_cnt, 0);
        launch(2, 4, 10, 50, 0, k);
        wait_done(0);
        report("after_reset", k);
        chk("after_reset_count", obs.size(), 16);
        chk("after_reset_done", done_cnt, 1);

        // Wrap
        launch(4, 4, 510, 2, 0, k);
        wait_done(0);
        report("wrap", k);
        chk("wrap_bar0_x0", 32'(obs[0].x), 510);
        chk("wrap_bar0_x1", 32'(obs[1].x), 511);
        chk("wrap_bar1_x0", 32'(obs[8].x), 1);
        chk("wrap_bar1_x1", 32'(obs[9].x), 2);
        chk("wrap_top_y", 32'(obs[6].y), 255);

        // Randomized passes with input noise during drawing
        for (int n = 0; n < 20; n++) begin
            bar_colour = 3'($urandom);
            bg_colour  = 3'($urandom);
            launch($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 511),
                   $urandom_range(0, 255), ($urandom_range(0, 3) == 0), k);
            wait_done(1);
            heights = '0; clear_only = 0;
            report("random", k);
            chk("random_count", obs.size(), 16);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
